// File: rtl/sha_msg_schedule.sv
// SHA-256 message schedule: loads one 512-bit block and streams W[0..ROUNDS-1] over a valid/ready handshake.
// Optional macro SHA_SCHED_PRELOAD_EN accepts the next block on the final word for back-to-back blocks.
module sha_msg_schedule #(
    parameter int ROUNDS = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    output logic         w_valid,
    input  logic         w_ready,
    output logic [31:0]  w_out,
    output logic [5:0]   w_idx,
    output logic         w_last
);

`ifdef SHA_SCHED_PRELOAD_EN
    localparam bit PRELOAD = 1'b1;
`else
    localparam bit PRELOAD = 1'b0;
`endif

    localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t      r_state;
    logic [31:0] r_win [16];
    logic [5:0]  r_t;
    logic        r_last;
    logic        r_blk_ready;
    logic        w_hs;
    logic [5:0]  w_t_next;
    logic [31:0] w_new;

    function automatic logic [31:0] f_sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] f_sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
    endfunction

    assign w_hs     = (r_state == S_RUN) && w_ready;
    assign w_t_next = r_t + 6'd1;
    assign w_new    = f_sigma1(r_win[14]) + r_win[9] + f_sigma0(r_win[1]) + r_win[0];

    // NOTE: all state is updated with non-blocking assignments so the window shift reads pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_t         <= 6'd0;
            r_last      <= 1'b0;
            r_blk_ready <= 1'b1;
            // NOTE: the window is small and must read as zero after reset, so it is reset like any register.
            for (int i = 0; i < 16; i++) r_win[i] <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (blk_valid) begin
                        for (int i = 0; i < 16; i++) r_win[i] <= blk_data[511-32*i -: 32];
                        r_t         <= 6'd0;
                        r_last      <= 1'b0;
                        r_blk_ready <= 1'b0;
                        r_state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_hs) begin
                        if (r_last) begin
                            if (PRELOAD && blk_valid) begin
                                // Back-to-back block: reload in place without leaving RUN.
                                for (int i = 0; i < 16; i++) r_win[i] <= blk_data[511-32*i -: 32];
                                r_t         <= 6'd0;
                                r_last      <= 1'b0;
                                r_blk_ready <= 1'b0;
                            end else begin
                                r_t         <= 6'd0;
                                r_last      <= 1'b0;
                                r_blk_ready <= 1'b1;
                                r_state     <= S_IDLE;
                            end
                        end else begin
                            for (int i = 0; i < 15; i++) r_win[i] <= r_win[i+1];
                            r_win[15]   <= w_new;
                            r_t         <= w_t_next;
                            r_last      <= (w_t_next == LAST_IDX);
                            r_blk_ready <= PRELOAD && (w_t_next == LAST_IDX);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign blk_ready = r_blk_ready;
    assign w_valid   = (r_state == S_RUN);
    assign w_out     = r_win[0];
    assign w_idx     = r_t;
    assign w_last    = r_last;

endmodule

// File: tb/tb_sha_msg_schedule.sv
// Directed bench for sha_msg_schedule: "abc" block, backpressure, busy rejection, mid-block reset, wrap arithmetic.
// Expected words come from hand constants and an independent full 64-word schedule model.
module tb_sha_msg_schedule;

`ifdef SHA_SCHED_PRELOAD_EN
    localparam bit PRELOAD = 1'b1;
`else
    localparam bit PRELOAD = 1'b0;
`endif
    localparam int ROUNDS = 64;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         blk_valid = 1'b0;
    logic         blk_ready;
    logic [511:0] blk_data = '0;
    logic         w_valid;
    logic         w_ready = 1'b0;
    logic [31:0]  w_out;
    logic [5:0]   w_idx;
    logic         w_last;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_w [64];
    logic [31:0] got_w [64];

    logic [511:0] blk_abc;
    logic [511:0] blk_ones;

    always #5 clk = ~clk;

    sha_msg_schedule #(.ROUNDS(ROUNDS)) dut (
        .clk       (clk),
        .reset     (reset),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_out     (w_out),
        .w_idx     (w_idx),
        .w_last    (w_last)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ref_s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ref_s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Textbook full-array schedule, independent of the sliding-window formulation.
    task automatic build_model(input logic [511:0] b);
        for (int i = 0; i < 16; i++) exp_w[i] = b[511-32*i -: 32];
        for (int i = 16; i < 64; i++)
            exp_w[i] = ref_s1(exp_w[i-2]) + exp_w[i-7] + ref_s0(exp_w[i-15]) + exp_w[i-16];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [511:0] b);
        int n = 0;
        blk_data  = b;
        blk_valid = 1'b1;
        while (!blk_ready && n < 200) begin
            step();
            n++;
        end
        check("accept_timeout", 64'(n < 200), 64'd1);
        step();
        blk_valid = 1'b0;
        check("first_valid", 64'(w_valid), 64'd1);
        check("first_idx", 64'(w_idx), 64'd0);
    endtask

    task automatic consume(input bit bp);
        int          idx  = 0;
        int          cyc  = 0;
        bit          hold = 1'b0;
        logic [31:0] pout = '0;
        logic [5:0]  pidx = '0;
        while (idx < ROUNDS && cyc < 1000) begin
            if (hold) begin
                check("hold_valid", 64'(w_valid), 64'd1);
                check("hold_out", 64'(w_out), 64'(pout));
                check("hold_idx", 64'(w_idx), 64'(pidx));
            end
            w_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (w_valid) begin
                check("busy_ready", 64'(blk_ready), 64'(PRELOAD && idx == ROUNDS - 1));
                if (w_ready) begin
                    got_w[idx] = w_out;
                    check($sformatf("w_out[%0d]", idx), 64'(w_out), 64'(exp_w[idx]));
                    check("w_idx", 64'(w_idx), 64'(idx));
                    check("w_last", 64'(w_last), 64'(idx == ROUNDS - 1));
                    idx++;
                end
            end
            hold = w_valid && !w_ready;
            pout = w_out;
            pidx = w_idx;
            step();
            cyc++;
        end
        check("word_count", 64'(idx), 64'(ROUNDS));
    endtask

    initial begin
        int gap;
        int n;
        blk_abc  = {32'h61626380, {14{32'h0}}, 32'h00000018};
        blk_ones = {16{32'hFFFFFFFF}};

        // Reset and idle, with w_ready high to show it has no effect.
        reset   = 1'b1;
        w_ready = 1'b1;
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("idle_blk_ready", 64'(blk_ready), 64'd1);
            check("idle_w_valid", 64'(w_valid), 64'd0);
            check("idle_w_out", 64'(w_out), 64'd0);
            check("idle_w_idx", 64'(w_idx), 64'd0);
            check("idle_w_last", 64'(w_last), 64'd0);
            step();
        end

        // "abc" block at full rate.
        build_model(blk_abc);
        send(blk_abc);
        consume(1'b0);
        check("abc_W0", 64'(got_w[0]), 64'h61626380);
        check("abc_W15", 64'(got_w[15]), 64'h00000018);
        check("abc_W16", 64'(got_w[16]), 64'h61626380);
        check("abc_W17", 64'(got_w[17]), 64'h000F0000);
        check("abc_W18", 64'(got_w[18]), 64'h7DA86405);
        check("abc_W63", 64'(got_w[63]), 64'h12B1EDEB);
        check("end_w_valid", 64'(w_valid), 64'd0);
        check("end_w_last", 64'(w_last), 64'd0);
        check("end_blk_ready", 64'(blk_ready), 64'd1);

        // Same block under random backpressure.
        send(blk_abc);
        consume(1'b1);
        check("bp_W63", 64'(got_w[63]), 64'h12B1EDEB);
        check("bp_end_w_valid", 64'(w_valid), 64'd0);

        // Second block held valid during RUN.
        send(blk_abc);
        blk_data  = blk_ones;
        blk_valid = 1'b1;
        consume(1'b0);
        gap = 0;
        while (!w_valid && gap < 10) begin
            gap++;
            step();
        end
        blk_valid = 1'b0;
        check("gap_cycles", 64'(gap), PRELOAD ? 64'd0 : 64'd1);
        check("blk2_W0", 64'(w_out), 64'hFFFFFFFF);
        check("blk2_idx", 64'(w_idx), 64'd0);

        // All-ones block exercises 32-bit wrap in the recurrence.
        build_model(blk_ones);
        consume(1'b0);
        check("ones_W16", 64'(got_w[16]), 64'h203FFFFC);
        check("ones_W17", 64'(got_w[17]), 64'h203FFFFC);
        check("ones_end_w_valid", 64'(w_valid), 64'd0);

        // Reset in the middle of a block.
        build_model(blk_abc);
        send(blk_abc);
        w_ready = 1'b1;
        n = 0;
        while (w_idx != 6'd20 && n < 100) begin
            step();
            n++;
        end
        check("reach_idx20", 64'(w_idx), 64'd20);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_w_valid", 64'(w_valid), 64'd0);
        check("rst_blk_ready", 64'(blk_ready), 64'd1);
        check("rst_w_idx", 64'(w_idx), 64'd0);
        check("rst_w_out", 64'(w_out), 64'd0);
        check("rst_w_last", 64'(w_last), 64'd0);
        step();
        step();
        check("rst_quiet", 64'(w_valid), 64'd0);
        send(blk_abc);
        check("rst_new_W0", 64'(w_out), 64'h61626380);
        consume(1'b0);
        check("rst_new_W63", 64'(got_w[63]), 64'h12B1EDEB);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
